// File: rtl/operand_mux_buf.sv
// N-input registered operand selector with a one-entry skid buffer; one-cycle latency when empty.
// Holds up to two words under back-pressure; in_ready comes from the skid flop only, never from out_ready.
module operand_mux_buf #(
  parameter int WIDTH  = 32,
  parameter int NUM_IN = 4,
  parameter int SEL_W  = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_IN*WIDTH-1:0] in_data,
  input  logic [SEL_W-1:0]        in_sel,
  input  logic                    in_valid,
  output logic                    in_ready,
  output logic [WIDTH-1:0]        out_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    sel_err
);

  logic [WIDTH-1:0] skid_data;
  logic             skid_full;
  logic [WIDTH-1:0] sel_word;
  logic             sel_ok;
  logic             acc;
  logic             fire;

  assign in_ready = ~skid_full;
  assign acc      = in_valid & ~skid_full;
  assign fire     = out_valid & out_ready;

  // Out-of-range selects yield zero and are flagged when accepted.
  always_comb begin
    sel_word = '0;
    sel_ok   = 1'b0;
    for (int k = 0; k < NUM_IN; k++) begin
      if (in_sel == SEL_W'(k)) begin
        sel_word = in_data[k*WIDTH +: WIDTH];
        sel_ok   = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_data  <= '0;
      out_valid <= 1'b0;
      skid_data <= '0;
      skid_full <= 1'b0;
      sel_err   <= 1'b0;
    end else begin
      if (skid_full) begin
        if (fire) begin
          out_data  <= skid_data;
          out_valid <= 1'b1;
          skid_full <= 1'b0;
        end
      end else if (!out_valid) begin
        if (acc) begin
          out_data  <= sel_word;
          out_valid <= 1'b1;
        end
      end else if (fire) begin
        // Accept and fire together replace the main word in place.
        if (acc) begin
          out_data <= sel_word;
        end else begin
          out_valid <= 1'b0;
        end
      end else if (acc) begin
        skid_data <= sel_word;
        skid_full <= 1'b1;
      end

      if (acc && !sel_ok) begin
        sel_err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_operand_mux_buf.sv
// Directed and randomized checks of operand_mux_buf against an ordered-queue reference model.
module tb_operand_mux_buf;

  localparam int WIDTH  = 8;
  localparam int NUM_IN = 3;
  localparam int SEL_W  = 2;

  logic                    clk = 1'b0;
  logic                    rst_n;
  logic [NUM_IN*WIDTH-1:0] in_data;
  logic [SEL_W-1:0]        in_sel;
  logic                    in_valid;
  logic                    in_ready;
  logic [WIDTH-1:0]        out_data;
  logic                    out_valid;
  logic                    out_ready;
  logic                    sel_err;

  operand_mux_buf #(.WIDTH(WIDTH), .NUM_IN(NUM_IN), .SEL_W(SEL_W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_data  (in_data),
    .in_sel   (in_sel),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .out_data (out_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .sel_err  (sel_err)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: words held in acceptance order, capacity two.
  logic [WIDTH-1:0] q[$];
  logic             err_m = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_model();
    chk("out_valid", 32'(out_valid), 32'(q.size() != 0));
    chk("in_ready", 32'(in_ready), 32'(q.size() < 2));
    chk("sel_err", 32'(sel_err), 32'(err_m));
    if (q.size() != 0) chk("out_data", 32'(out_data), 32'(q[0]));
  endtask

  // Advance one clock, update the model from the inputs presented before the edge, then check.
  task automatic cycle();
    logic             a, f;
    logic [WIDTH-1:0] w;
    a = in_valid && (q.size() < 2);
    f = (q.size() != 0) && out_ready;
    w = (int'(in_sel) < NUM_IN) ? in_data[int'(in_sel)*WIDTH +: WIDTH] : '0;
    @(posedge clk);
    #1;
    if (f) void'(q.pop_front());
    if (a) begin
      q.push_back(w);
      if (int'(in_sel) >= NUM_IN) err_m = 1'b1;
    end
    check_model();
  endtask

  initial begin
    rst_n     = 1'b0;
    in_data   = {8'h33, 8'h22, 8'h11};
    in_sel    = '0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    #3;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_sel_err", 32'(sel_err), 32'd0);
    chk("rst_out_data", 32'(out_data), 32'd0);
    #9 rst_n = 1'b1;
    cycle();

    // Steady stream, one word per cycle.
    out_ready = 1'b1; in_valid = 1'b1;
    in_sel = 2'd0; cycle(); chk("stream0", 32'(out_data), 32'h11);
    in_sel = 2'd1; cycle(); chk("stream1", 32'(out_data), 32'h22);
    in_sel = 2'd2; cycle(); chk("stream2", 32'(out_data), 32'h33);
    in_valid = 1'b0; cycle(); chk("stream_drain", 32'(out_valid), 32'd0);

    // Stall fills the skid; third word is refused until the skid drains.
    in_valid = 1'b1; in_sel = 2'd0; cycle();
    out_ready = 1'b0; in_sel = 2'd1; cycle();
    chk("stall_ready", 32'(in_ready), 32'd0);
    chk("stall_hold", 32'(out_data), 32'h11);
    in_sel = 2'd2; cycle();
    chk("stall_refuse", 32'(out_data), 32'h11);
    out_ready = 1'b1; cycle();
    chk("stall_skid_out", 32'(out_data), 32'h22);
    chk("stall_ready_back", 32'(in_ready), 32'd1);
    cycle();
    chk("stall_reoffer", 32'(out_data), 32'h33);
    in_valid = 1'b0; cycle();

    // Out-of-range select.
    in_valid = 1'b1; in_sel = 2'd3; cycle();
    chk("oor_data", 32'(out_data), 32'h00);
    chk("oor_err", 32'(sel_err), 32'd1);
    in_sel = 2'd0; cycle();
    chk("oor_sticky", 32'(sel_err), 32'd1);

    // Idle input with bad select and garbage data changes nothing.
    out_ready = 1'b0; in_valid = 1'b0; in_sel = 2'd3; in_data = 24'hA5C3E7;
    cycle();
    chk("idle_data", 32'(out_data), 32'h11);
    chk("idle_err", 32'(sel_err), 32'd1);
    in_data = {8'h33, 8'h22, 8'h11};

    // Asynchronous reset with both registers full.
    in_valid = 1'b1; in_sel = 2'd1; cycle();
    chk("full_ready", 32'(in_ready), 32'd0);
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    q.delete(); err_m = 1'b0;
    chk("arst_valid", 32'(out_valid), 32'd0);
    chk("arst_ready", 32'(in_ready), 32'd1);
    chk("arst_err", 32'(sel_err), 32'd0);
    #1 rst_n = 1'b1;
    in_valid = 1'b1; in_sel = 2'd2; out_ready = 1'b1; cycle();
    chk("arst_first", 32'(out_data), 32'h33);
    in_valid = 1'b0; cycle();

    // Randomized traffic against the model.
    for (int i = 0; i < 10000; i++) begin
      in_valid  = 1'($urandom_range(0, 1));
      in_sel    = SEL_W'($urandom_range(0, 3));
      in_data   = 24'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      #1;
      out_ready = ~out_ready;
      #1;
      chk("rand_ready_indep", 32'(in_ready), 32'(q.size() < 2));
      out_ready = ~out_ready;
      cycle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
